// File: rtl/ble_cluster_pkg.sv
// ============================================================================
//  Module      : ble_cluster_pkg
//  Description : Shared helpers for the BLE cluster. Provides a ceiling-log2
//                function, the derived-width functions for the select field,
//                the per-BLE configuration word and the whole chain, and the
//                field offsets inside one BLE configuration word.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ble_cluster_pkg;

    // Ceiling log2, returning at least 1 so a field never collapses to 0 bits.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int b = 1; b < 31; b++) begin
            if ((1 << b) < v) begin
                r = b + 1;
            end
        end
        return r;
    endfunction

    // Width of one LUT input-select field: codes cover {in, q} plus spare codes.
    function automatic int sel_w(input int i_cnt, input int n_cnt);
        return clog2(i_cnt + n_cnt);
    endfunction

    // Configuration bits per BLE: K selects, out_sel, ff_init, 2**K LUT bits.
    function automatic int ble_w(input int k_cnt, input int sw);
        return k_cnt * sw + 2 + (1 << k_cnt);
    endfunction

    // Total configuration chain length.
    function automatic int cfg_w(input int n_cnt, input int bw);
        return n_cnt * bw;
    endfunction

    // Field offsets relative to the base of a BLE configuration word.
    localparam int OFS_SEL = 0;

    function automatic int ofs_outsel(input int k_cnt, input int sw);
        return k_cnt * sw;
    endfunction

    function automatic int ofs_ffinit(input int k_cnt, input int sw);
        return k_cnt * sw + 1;
    endfunction

    function automatic int ofs_lut(input int k_cnt, input int sw);
        return k_cnt * sw + 2;
    endfunction

endpackage : ble_cluster_pkg

`default_nettype wire

// File: rtl/ble_slice.sv
// ============================================================================
//  Module      : ble_slice
//  Description : One basic logic element: K input-select muxes over the
//                cluster inputs and the cluster's registered outputs, a
//                K-input LUT, an output register with init-load and enable,
//                and the out_sel mux choosing registered or LUT output.
//  Ports       : clk, rst_n      clock / async active-low reset
//                i_cfg           this BLE's configuration word
//                i_in            cluster inputs
//                i_q_fb          registered outputs of all BLEs (feedback)
//                i_load          load ff_init into the register
//                i_upd           capture the LUT output into the register
//                o_q             register value
//                o_out           selected (ungated) BLE output
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ble_slice
    import ble_cluster_pkg::*;
#(
    parameter int K     = 4,
    parameter int N     = 4,
    parameter int I     = 10,
    parameter int SEL_W = sel_w(I, N),
    parameter int BLE_W = ble_w(K, SEL_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BLE_W-1:0] i_cfg,
    input  logic [I-1:0]     i_in,
    input  logic [N-1:0]     i_q_fb,
    input  logic             i_load,
    input  logic             i_upd,
    output logic             o_q,
    output logic             o_out
);

    localparam int SRC_W      = 1 << SEL_W;
    localparam int LUT_SIZE   = 1 << K;
    localparam int OFS_OUTSEL = ofs_outsel(K, SEL_W);
    localparam int OFS_FFINIT = ofs_ffinit(K, SEL_W);
    localparam int OFS_LUT    = ofs_lut(K, SEL_W);

    logic [SRC_W-1:0]    w_src;
    logic [K-1:0]        w_idx;
    logic [LUT_SIZE-1:0] w_lut_tbl;
    logic                w_lut_out;
    logic                r_q;

    // Source vector indexed directly by a select code: inputs first, then
    // feedback from the registers, spare codes read as constant 0. Feedback
    // is taken from q only, so no combinational loop can be configured.
    always_comb begin
        w_src            = '0;
        w_src[I-1:0]     = i_in;
        w_src[I+N-1:I]   = i_q_fb;
    end

    for (genvar m = 0; m < K; m++) begin : g_sel
        logic [SEL_W-1:0] w_code;
        assign w_code   = i_cfg[OFS_SEL + m*SEL_W +: SEL_W];
        assign w_idx[m] = w_src[w_code];
    end

    assign w_lut_tbl = i_cfg[OFS_LUT +: LUT_SIZE];
    assign w_lut_out = w_lut_tbl[w_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (i_load) begin
            r_q <= i_cfg[OFS_FFINIT];
        end else if (i_upd) begin
            r_q <= w_lut_out;
        end
    end

    assign o_q   = r_q;
    assign o_out = i_cfg[OFS_OUTSEL] ? r_q : w_lut_out;

endmodule : ble_slice

`default_nettype wire

// File: rtl/ble_cluster.sv
// ============================================================================
//  Module      : ble_cluster
//  Description : Cluster of N BLEs configured through one serial shift chain.
//                Tracks the length of each programming session and only
//                enables the outputs once a session of exactly CFG_W shifts
//                has completed.
//  Ports       : clk, rst_n      clock / async active-low reset
//                prog_en         shift enable for the configuration chain
//                prog_in         serial configuration data in
//                prog_out        serial configuration data out (chain[0])
//                ce              clock enable for the BLE registers
//                in              cluster inputs
//                out             BLE outputs, 0 while unconfigured
//                cfg_valid       complete, correctly sized config loaded
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ble_cluster
    import ble_cluster_pkg::*;
#(
    parameter int K = 4,
    parameter int N = 4,
    parameter int I = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         prog_en,
    input  logic         prog_in,
    output logic         prog_out,
    input  logic         ce,
    input  logic [I-1:0] in,
    output logic [N-1:0] out,
    output logic         cfg_valid
);

    localparam int SEL_W = sel_w(I, N);
    localparam int BLE_W = ble_w(K, SEL_W);
    localparam int CFG_W = cfg_w(N, BLE_W);
    localparam int CNT_W = clog2(CFG_W + 2);

    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(CFG_W + 1);

    logic [CFG_W-1:0] r_chain;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pe_d;
    logic             r_cfg_valid;

    logic             w_load;
    logic             w_upd;
    logic [N-1:0]     w_q;
    logic [N-1:0]     w_slice_out;

    // Falling edge of prog_en ends a session and loads the configuration.
    assign w_load = ~prog_en & r_pe_d;
    assign w_upd  = r_cfg_valid & ~prog_en & ~w_load & ce;

    // Configuration chain: new bits enter at the top and leave from bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else if (prog_en) begin
            r_chain <= {prog_in, r_chain[CFG_W-1:1]};
        end
    end

    // Session length counter. Saturating one past full length lets an
    // overlong session be told apart from an exact one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pe_d      <= 1'b0;
            r_cnt       <= '0;
            r_cfg_valid <= 1'b0;
        end else begin
            r_pe_d <= prog_en;
            if (prog_en) begin
                if (!r_pe_d) begin
                    r_cnt       <= C_CNT_ONE;
                    r_cfg_valid <= 1'b0;
                end else if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end
            end else if (r_pe_d) begin
                r_cfg_valid <= (r_cnt == C_CNT_FULL);
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_ble
        ble_slice #(
            .K     (K),
            .N     (N),
            .I     (I),
            .SEL_W (SEL_W),
            .BLE_W (BLE_W)
        ) u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_cfg  (r_chain[j*BLE_W +: BLE_W]),
            .i_in   (in),
            .i_q_fb (w_q),
            .i_load (w_load),
            .i_upd  (w_upd),
            .o_q    (w_q[j]),
            .o_out  (w_slice_out[j])
        );
    end

    assign prog_out  = r_chain[0];
    assign cfg_valid = r_cfg_valid;
    assign out       = r_cfg_valid ? w_slice_out : '0;

endmodule : ble_cluster

`default_nettype wire

// File: tb/tb_ble_cluster.sv
// ============================================================================
//  Module      : tb_ble_cluster
//  Description : Self-checking bench for ble_cluster. A driver applies random
//                stimulus and pushes the reference model's expected outputs
//                into a scoreboard queue; a monitor pops and compares them on
//                the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ble_cluster;
    import ble_cluster_pkg::*;

    localparam int K     = 4;
    localparam int N     = 4;
    localparam int I     = 10;
    localparam int SEL_W = sel_w(I, N);
    localparam int BLE_W = ble_w(K, SEL_W);
    localparam int CFG_W = cfg_w(N, BLE_W);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         prog_en;
    logic         prog_in;
    logic         prog_out;
    logic         ce;
    logic [I-1:0] in_r;
    logic [N-1:0] out_w;
    logic         cfg_valid;

    ble_cluster #(.K(K), .N(N), .I(I)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_en   (prog_en),
        .prog_in   (prog_in),
        .prog_out  (prog_out),
        .ce        (ce),
        .in        (in_r),
        .out       (out_w),
        .cfg_valid (cfg_valid)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [N-1:0] out;
        logic         cv;
        logic         po;
    } exp_t;

    exp_t  sbq[$];
    string nmq[$];
    int    checks = 0;
    int    errors = 0;

    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            exp_t  e;
            string nm;
            e  = sbq.pop_front();
            nm = nmq.pop_front();
            checks++;
            if (out_w !== e.out || cfg_valid !== e.cv || prog_out !== e.po) begin
                errors++;
                $display("FAIL %s @%0t: got out=%h cfg_valid=%b prog_out=%b, expected out=%h cfg_valid=%b prog_out=%b",
                         nm, $time, out_w, cfg_valid, prog_out, e.out, e.cv, e.po);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: configuration held as a plain bit array; a session
    // is valid iff exactly CFG_W bits were shifted while prog_en was high.
    // ------------------------------------------------------------------
    logic [CFG_W-1:0] m_chain;
    logic [N-1:0]     m_q;
    logic             m_valid;
    int               m_len;
    logic             m_pe_d;

    function automatic int m_field(int j, int off, int w);
        int v = 0;
        for (int b = 0; b < w; b++) begin
            if (m_chain[j*BLE_W + off + b]) v += (1 << b);
        end
        return v;
    endfunction

    function automatic logic m_lut(int j, logic [I-1:0] iv);
        int idx = 0;
        for (int m = 0; m < K; m++) begin
            int   s;
            logic bitv;
            s = m_field(j, m*SEL_W, SEL_W);
            if (s < I)          bitv = iv[s];
            else if (s < I + N) bitv = m_q[s-I];
            else                bitv = 1'b0;
            if (bitv) idx += (1 << m);
        end
        return m_chain[j*BLE_W + K*SEL_W + 2 + idx];
    endfunction

    function automatic logic [N-1:0] m_out(logic [I-1:0] iv);
        logic [N-1:0] o = '0;
        if (m_valid) begin
            for (int j = 0; j < N; j++) begin
                o[j] = m_chain[j*BLE_W + K*SEL_W] ? m_q[j] : m_lut(j, iv);
            end
        end
        return o;
    endfunction

    task automatic model_reset();
        m_chain = '0;
        m_q     = '0;
        m_valid = 1'b0;
        m_len   = 0;
        m_pe_d  = 1'b0;
    endtask

    task automatic model_step(logic pe, logic pin, logic cev, logic [I-1:0] iv);
        logic [N-1:0] nq;
        logic         load;
        load = !pe && m_pe_d;
        for (int j = 0; j < N; j++) begin
            if (load)                      nq[j] = m_chain[j*BLE_W + K*SEL_W + 1];
            else if (m_valid && !pe && cev) nq[j] = m_lut(j, iv);
            else                           nq[j] = m_q[j];
        end
        if (pe) begin
            m_len   = m_pe_d ? m_len + 1 : 1;
            m_valid = 1'b0;
            m_chain = {pin, m_chain[CFG_W-1:1]};
        end else if (load) begin
            m_valid = (m_len == CFG_W);
        end
        m_q    = nq;
        m_pe_d = pe;
    endtask

    task automatic push_exp(string nm);
        exp_t e;
        e.out = m_out(in_r);
        e.cv  = m_valid;
        e.po  = m_chain[0];
        sbq.push_back(e);
        nmq.push_back(nm);
    endtask

    // One clock cycle: drive, predict, advance the model with the edge.
    task automatic cycle(logic pe, logic pin, logic cev, logic [I-1:0] iv, string nm);
        prog_en = pe;
        prog_in = pin;
        ce      = cev;
        in_r    = iv;
        push_exp(nm);
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step(pe, pin, cev, iv);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Configuration building
    // ------------------------------------------------------------------
    int          p_sel[N][K];
    logic        p_os[N];
    logic        p_fi[N];
    logic [15:0] p_lut[N];

    task automatic rand_fields();
        for (int j = 0; j < N; j++) begin
            for (int m = 0; m < K; m++) p_sel[j][m] = $urandom_range(0, (1 << SEL_W) - 1);
            p_os[j]  = 1'($urandom);
            p_fi[j]  = 1'($urandom);
            p_lut[j] = 16'($urandom);
        end
    endtask

    function automatic logic [CFG_W-1:0] pack_cfg();
        logic [CFG_W-1:0] v = '0;
        for (int j = 0; j < N; j++) begin
            for (int m = 0; m < K; m++) v[j*BLE_W + m*SEL_W +: SEL_W] = SEL_W'(p_sel[j][m]);
            v[j*BLE_W + K*SEL_W]              = p_os[j];
            v[j*BLE_W + K*SEL_W + 1]          = p_fi[j];
            v[j*BLE_W + K*SEL_W + 2 +: 16]    = p_lut[j];
        end
        return v;
    endfunction

    // Shift len bits (extra bits beyond CFG_W are random), then end the session.
    task automatic session(int len, string nm);
        logic [CFG_W-1:0] pat;
        pat = pack_cfg();
        for (int i = 0; i < len; i++) begin
            cycle(1'b1, (i < CFG_W) ? pat[i] : 1'($urandom), 1'($urandom), I'($urandom), nm);
        end
        cycle(1'b0, 1'b0, 1'b1, I'($urandom), {nm, "_load"});
    endtask

    task automatic run(int n, int ce_pct, string nm);
        for (int c = 0; c < n; c++) begin
            cycle(1'b0, 1'($urandom), ($urandom_range(0, 99) < ce_pct), I'($urandom), nm);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n   = 1'b0;
        prog_en = 1'b0;
        prog_in = 1'b0;
        ce      = 1'b0;
        in_r    = '0;
        model_reset();
        push_exp("reset_state");
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b0, 1'b1, I'($urandom), "reset_hold");
        rst_n = 1'b1;

        // Reset asserted part way through a shift session, between edges.
        rand_fields();
        begin
            logic [CFG_W-1:0] pat;
            pat = pack_cfg();
            for (int i = 0; i < 50; i++) cycle(1'b1, pat[i], 1'b1, I'($urandom), "pre_reset_shift");
        end
        #1;
        rst_n   = 1'b0;
        prog_en = 1'b0;
        model_reset();
        push_exp("async_reset_mid_shift");
        #1;
        checks++;
        if (out_w !== '0 || cfg_valid !== 1'b0 || prog_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate @%0t: out=%h cfg_valid=%b prog_out=%b",
                     $time, out_w, cfg_valid, prog_out);
        end
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b0, 1'b1, I'($urandom), "reset_held");
        rst_n = 1'b1;
        run(5, 100, "after_reset");

        // Pass-through: every BLE outputs in[0] combinationally.
        rand_fields();
        for (int j = 0; j < N; j++) begin
            p_sel[j][0] = 0;
            p_lut[j]    = 16'hAAAA;
            p_os[j]     = 1'b0;
        end
        session(CFG_W, "passthru_shift");
        checks++;
        if (cfg_valid !== 1'b1) begin
            errors++;
            $display("FAIL passthru_cfg_valid @%0t: cfg_valid=%b expected 1", $time, cfg_valid);
        end
        for (int v = 0; v < (1 << I); v++) begin
            cycle(1'b0, 1'b0, 1'($urandom), I'(v), "passthru_all_inputs");
        end

        // Reload random config; prog_out must replay the previous pattern.
        rand_fields();
        session(CFG_W, "readback_shift");
        run(150, 70, "random_config_run");

        // Short session: outputs stay dead, chain retained.
        rand_fields();
        session(CFG_W - 1, "short_shift");
        checks++;
        if (cfg_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_cfg_valid @%0t: cfg_valid=%b expected 0", $time, cfg_valid);
        end
        run(30, 80, "short_session_run");
        rand_fields();
        session(CFG_W, "full_after_short");
        run(30, 80, "full_after_short_run");

        // Toggle counter on BLE0, one-cycle delayed copy on BLE1,
        // spare select codes reading 0 on BLE2.
        rand_fields();
        for (int m = 0; m < K; m++) begin
            p_sel[0][m] = I;
            p_sel[1][m] = I;
            p_sel[2][m] = 15;
        end
        p_lut[0] = 16'h5555; p_os[0] = 1'b1; p_fi[0] = 1'b1;
        p_lut[1] = 16'hAAAA; p_os[1] = 1'b1; p_fi[1] = 1'b0;
        p_lut[2] = 16'hAAAA; p_os[2] = 1'b0;
        session(CFG_W, "toggle_shift");
        run(20, 100, "toggle_ce1");
        run(10, 0, "toggle_hold_ce0");
        run(40, 60, "toggle_random_ce");

        // Single-cycle prog_en mid-operation: drops cfg_valid, freezes q.
        session(1, "one_cycle_prog_en");
        run(10, 100, "after_one_cycle_session");

        // Overlong session.
        rand_fields();
        session(CFG_W + 1, "overlong_shift");
        checks++;
        if (cfg_valid !== 1'b0) begin
            errors++;
            $display("FAIL overlong_cfg_valid @%0t: cfg_valid=%b expected 0", $time, cfg_valid);
        end
        run(10, 100, "overlong_run");

        // Recovery with a full session.
        rand_fields();
        session(CFG_W, "final_shift");
        checks++;
        if (cfg_valid !== 1'b1) begin
            errors++;
            $display("FAIL final_cfg_valid @%0t: cfg_valid=%b expected 1", $time, cfg_valid);
        end
        run(40, 75, "final_run");

        @(negedge clk);
        @(negedge clk);
        if (errors == 0) begin
            $display("PASS Simulation finished: %0d checks, %0d errors", checks, errors);
        end else begin
            $display("FAIL Simulation finished: %0d checks, %0d errors", checks, errors);
        end
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule : tb_ble_cluster

`default_nettype wire
